// File: rtl/cpu_types_pkg.sv
// Shared CPU type definitions: instruction-cache address split and field widths.
package cpu_types_pkg;

    localparam int IBYT_W = 2;
    localparam int IIDX_W = 4;
    localparam int ITAG_W = 32 - IIDX_W - IBYT_W;

    typedef struct packed {
        logic [ITAG_W-1:0] tag;
        logic [IIDX_W-1:0] idx;
        logic [IBYT_W-1:0] bytoff;
    } icachef_t;

endpackage

// File: rtl/icache.sv
// Direct-mapped instruction cache, one word per frame, blocking single-miss FSM.
// Hit returns in zero cycles; a miss costs memory latency + 2 cycles, fetch stalls on ihit=0.
module icache
    import cpu_types_pkg::*;
#(
    parameter int NFRAMES = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic [31:0] iload,
    input  logic        iwait
);

    localparam int IDX_W = $clog2(NFRAMES);
    localparam int TAG_W = 32 - IDX_W - IBYT_W;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] FETCH = 1'b1;

    logic [0:0]         state_q, state_d;
    logic [31:0]        miss_addr_q, miss_addr_d;
    logic [NFRAMES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q  [NFRAMES];
    logic [31:0]        data_q [NFRAMES];

    logic [IDX_W-1:0] req_idx, miss_idx;
    logic [TAG_W-1:0] req_tag, miss_tag;
    logic             hit;
    logic             fill;
    logic             unused_bytoff;

    assign req_idx  = imemaddr[IDX_W+IBYT_W-1:IBYT_W];
    assign req_tag  = imemaddr[31:IDX_W+IBYT_W];
    assign miss_idx = miss_addr_q[IDX_W+IBYT_W-1:IBYT_W];
    assign miss_tag = miss_addr_q[31:IDX_W+IBYT_W];

    // Byte offset never participates in lookup: frames hold whole words.
    assign unused_bytoff = ^{imemaddr[IBYT_W-1:0], miss_addr_q[IBYT_W-1:0]};

    assign hit  = (state_q == IDLE) && imemREN && valid_q[req_idx]
                  && (tag_q[req_idx] == req_tag);
    assign fill = (state_q == FETCH) && !iwait;

    always_comb begin
        state_d     = state_q;
        miss_addr_d = miss_addr_q;
        if (state_q == IDLE) begin
            if (imemREN && !hit) begin
                state_d     = FETCH;
                miss_addr_d = imemaddr;
            end
        end else if (!iwait) begin
            state_d = IDLE;
        end
    end

    assign ihit     = hit;
    assign imemload = hit ? data_q[req_idx] : 32'h0;
    assign iREN     = (state_q == FETCH);
    // Memory sees the latched miss address so fetch-stage address changes cannot corrupt the fill.
    assign iaddr    = (state_q == FETCH) ? miss_addr_q : 32'h0;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            miss_addr_q <= '0;
            valid_q     <= '0;
            for (int i = 0; i < NFRAMES; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
            if (fill) begin
                valid_q[miss_idx] <= 1'b1;
                tag_q[miss_idx]   <= miss_tag;
                data_q[miss_idx]  <= iload;
            end
        end
    end

endmodule

// File: tb/tb_icache.sv
// Bench for icache: word-address cache model, memory responder with programmable latency.
module tb_icache;

    localparam int NF = 16;

    logic        CLK;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] iload;
    logic        iwait;

    int n_cmp = 0;
    int n_bad = 0;
    int mem_lat = 3;
    logic [7:0] mcnt;

    icache #(.NFRAMES(NF)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .imemREN  (imemREN),
        .imemaddr (imemaddr),
        .ihit     (ihit),
        .imemload (imemload),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iload    (iload),
        .iwait    (iwait)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h40) return 32'h2401_0005;
        if (a == 32'h80) return 32'h8c22_0000;
        return a ^ 32'hA5A5_0000;
    endfunction

    // Memory: busy for mem_lat cycles of a request, then one ready cycle.
    always @(posedge CLK or negedge nRST) begin
        if (!nRST)     mcnt <= 8'd0;
        else if (iREN) mcnt <= mcnt + 8'd1;
        else           mcnt <= 8'd0;
    end
    assign iwait = !(iREN && (int'(mcnt) >= mem_lat));
    assign iload = mem_word(iaddr);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Cache model: word address stored per frame; one outstanding miss.
    bit          m_valid [NF];
    logic [29:0] m_waddr [NF];
    logic [31:0] m_data  [NF];
    bit          m_busy = 1'b0;
    logic [31:0] m_miss = 32'h0;

    function automatic int frame_of(input logic [31:0] a);
        return int'((a >> 2) % NF);
    endfunction

    function automatic bit m_lookup(input logic [31:0] a);
        return m_valid[frame_of(a)] && (m_waddr[frame_of(a)] == a[31:2]);
    endfunction

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            m_busy = 1'b0;
            m_miss = 32'h0;
            for (int i = 0; i < NF; i++) m_valid[i] = 1'b0;
        end else if (m_busy) begin
            if (!iwait) begin
                m_valid[frame_of(m_miss)] = 1'b1;
                m_waddr[frame_of(m_miss)] = m_miss[31:2];
                m_data[frame_of(m_miss)]  = mem_word(m_miss);
                m_busy = 1'b0;
            end
        end else if (imemREN && !m_lookup(imemaddr)) begin
            m_busy = 1'b1;
            m_miss = imemaddr;
        end
    end

    always @(negedge CLK) begin : compare
        bit          e_hit;
        logic [31:0] e_load;
        e_hit  = (nRST === 1'b1) && !m_busy && (imemREN === 1'b1) && m_lookup(imemaddr);
        e_load = e_hit ? m_data[frame_of(imemaddr)] : 32'h0;
        chk("mdl_ihit",     {31'h0, ihit}, {31'h0, e_hit});
        chk("mdl_imemload", imemload, e_load);
        chk("mdl_iREN",     {31'h0, iREN}, {31'h0, m_busy});
        chk("mdl_iaddr",    iaddr, m_busy ? m_miss : 32'h0);
    end

    task automatic drive(input logic ren, input logic [31:0] a);
        @(posedge CLK);
        #1;
        imemREN  = ren;
        imemaddr = a;
    endtask

    task automatic wait_hit(input string nm);
        int k = 0;
        while (ihit !== 1'b1 && k < 200) begin
            @(negedge CLK);
            k++;
        end
        if (k >= 200) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: ihit never rose within 200 cycles", nm);
        end
    endtask

    logic [31:0] sweep [7];

    initial begin
        nRST = 1'b0;
        imemREN = 1'b0;
        imemaddr = 32'h0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_ihit", {31'h0, ihit}, 32'h0);
        chk("rst_imemload", imemload, 32'h0);
        chk("rst_iREN", {31'h0, iREN}, 32'h0);
        chk("rst_iaddr", iaddr, 32'h0);

        // Cold miss on 0x40 with three busy cycles
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        imemREN = 1'b1;
        imemaddr = 32'h40;
        @(negedge CLK);
        chk("cold_idle_ihit", {31'h0, ihit}, 32'h0);
        chk("cold_idle_iREN", {31'h0, iREN}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk("cold_iREN", {31'h0, iREN}, 32'h1);
            chk("cold_iaddr", iaddr, 32'h40);
            chk("cold_ihit", {31'h0, ihit}, 32'h0);
        end
        @(negedge CLK);
        chk("cold_hit", {31'h0, ihit}, 32'h1);
        chk("cold_load", imemload, 32'h2401_0005);

        drive(1'b0, 32'h40);
        @(negedge CLK);
        chk("noren_ihit", {31'h0, ihit}, 32'h0);
        chk("noren_load", imemload, 32'h0);

        drive(1'b1, 32'h42);
        @(negedge CLK);
        chk("rehit_ihit", {31'h0, ihit}, 32'h1);
        chk("rehit_load", imemload, 32'h2401_0005);
        chk("rehit_iREN", {31'h0, iREN}, 32'h0);

        // Conflict in frame 0
        drive(1'b1, 32'h80);
        @(negedge CLK);
        chk("conf80_miss", {31'h0, ihit}, 32'h0);
        wait_hit("conf80");
        chk("conf80_load", imemload, 32'h8c22_0000);
        drive(1'b1, 32'h40);
        @(negedge CLK);
        chk("evict40_miss", {31'h0, ihit}, 32'h0);
        wait_hit("evict40");
        chk("evict40_load", imemload, 32'h2401_0005);

        // Address change while the fill is outstanding
        drive(1'b1, 32'h104);
        drive(1'b1, 32'h208);
        @(negedge CLK);
        chk("chg_iREN", {31'h0, iREN}, 32'h1);
        chk("chg_iaddr", iaddr, 32'h104);
        begin
            int k = 0;
            while (iREN === 1'b1 && k < 50) begin
                @(negedge CLK);
                k++;
            end
            chk("chg_fill_done", {31'h0, iREN}, 32'h0);
        end
        chk("chg_new_miss", {31'h0, ihit}, 32'h0);
        @(negedge CLK);
        chk("chg_new_iaddr", iaddr, 32'h208);
        wait_hit("chg208");
        chk("chg208_load", imemload, 32'hA5A5_0208);
        drive(1'b1, 32'h104);
        @(negedge CLK);
        chk("chg104_hit", {31'h0, ihit}, 32'h1);
        chk("chg104_load", imemload, 32'hA5A5_0104);

        // Reset while a long fetch is outstanding
        mem_lat = 40;
        drive(1'b1, 32'h30C);
        repeat (3) @(negedge CLK);
        chk("rf_busy", {31'h0, iREN}, 32'h1);
        #2;
        nRST = 1'b0;
        #1;
        chk("rf_iREN_async", {31'h0, iREN}, 32'h0);
        chk("rf_iaddr_async", iaddr, 32'h0);
        repeat (2) @(posedge CLK);
        #1;
        mem_lat = 2;
        nRST = 1'b1;
        imemREN = 1'b1;
        imemaddr = 32'h40;
        @(negedge CLK);
        chk("rf_40_miss", {31'h0, ihit}, 32'h0);
        wait_hit("rf40");
        chk("rf40_load", imemload, 32'h2401_0005);
        drive(1'b1, 32'h30C);
        @(negedge CLK);
        chk("rf_30c_miss", {31'h0, ihit}, 32'h0);
        wait_hit("rf30c");
        chk("rf30c_load", imemload, 32'hA5A5_030C);

        // Short sweep mixing hits, misses and conflicts
        mem_lat = 1;
        sweep = '{32'h0, 32'h4, 32'h40, 32'h44, 32'h1, 32'h80, 32'h6};
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, sweep[i]);
            @(negedge CLK);
            wait_hit("sweep");
        end
        drive(1'b0, 32'h0);
        repeat (3) @(negedge CLK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
